proc_ctrl_seq: RTL and testbench

Explicit-state control sequencer for the 16-bit simple processor datapath: eight GP registers, IR/A/G/H, bus multiplexer and ALU. It drives every datapath control signal and takes instructions through a valid/ack handshake. Instruction latency varies by opcode: 2 to 4 steps, plus an open-ended wait on an external multi-cycle multiplier guarded by a timeout. The `tick` output keeps the one-hot step display used on HEX5.

---
 rtl/proc_ctrl_pkg.sv | 59 +++++
 rtl/proc_ctrl_seq.sv | 205 ++++++++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg
// Shared constants for the simple-processor control sequencer:
//   - opcode field values of the 9-bit IR
//   - bus multiplexer source selects
//   - ALU operation codes
//   - bit positions of the special-register write enables
//   - sequencer state enumeration and its one-hot step display encoding
package proc_ctrl_pkg;

    // Opcodes (IR[8:6])
    localparam logic [2:0] OP_DISP = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_SLL  = 3'd6;
    localparam logic [2:0] OP_MOVI = 3'd7;

    // Bus sources beyond R0..R7
    localparam logic [3:0] BUS_G   = 4'd8;
    localparam logic [3:0] BUS_DIN = 4'd9;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;

    // Bit positions within sp_reg_write
    localparam int SP_IR = 0;
    localparam int SP_A  = 1;
    localparam int SP_G  = 2;
    localparam int SP_H  = 3;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_T2,
        ST_T3,
        ST_MUL_WAIT,
        ST_T4
    } state_t;

    // One-hot step display; the multiplier wait shares T3's digit.
    function automatic logic [3:0] tick_of(input state_t s);
        logic [3:0] t;
        case (s)
            ST_FETCH:    t = 4'b0001;
            ST_T2:       t = 4'b0010;
            ST_T3:       t = 4'b0100;
            ST_MUL_WAIT: t = 4'b0100;
            ST_T4:       t = 4'b1000;
            default:     t = 4'b0001;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/proc_ctrl_seq.sv
// proc_ctrl_seq
// Explicit-state control sequencer for the 16-bit simple processor datapath.
// Accepts an instruction through instr_valid/instr_ack, then steps through
// 2..4 control steps (plus a bounded wait on an external multiplier),
// driving every datapath enable and select combinationally from the state.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   instr_valid     instruction word present on din (only looked at in FETCH)
//   instr_ack       IR loads at this edge
//   ir[8:0]         IR contents: opcode[8:6], rx[5:3], ry[2:0]
//   mul_done        external multiplier result valid
//   mul_start       one-cycle multiplier start pulse
//   gp_reg_write    R0..R7 write enables
//   sp_reg_write    IR/A/G/H write enables (bits 0..3)
//   bus_control     bus source: 0-7 Rn, 8 G, 9 sign-extended din
//   alu_op          ALU operation
//   tick            one-hot step display
//   done            final step of an instruction
//   err             sticky multiply-timeout flag, cleared by the next ack
//   retire_count    completed-instruction counter, wraps
module proc_ctrl_seq
    import proc_ctrl_pkg::*;
#(
    parameter int MUL_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ack,
    input  logic [8:0]           ir,
    input  logic                 mul_done,
    output logic                 mul_start,
    output logic [7:0]           gp_reg_write,
    output logic [3:0]           sp_reg_write,
    output logic [3:0]           bus_control,
    output logic [2:0]           alu_op,
    output logic [3:0]           tick,
    output logic                 done,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] retire_count
);

    localparam int WAIT_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MUL_TIMEOUT - 1);

    state_t                state_reg, state_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic                  err_reg, err_next;
    logic [CNT_WIDTH-1:0]  retire_reg;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_onehot;

    assign opcode    = ir[8:6];
    assign rx        = ir[5:3];
    assign ry        = ir[2:0];
    assign rx_onehot = 8'(1) << rx;

    assign err          = err_reg;
    assign retire_count = retire_reg;
    assign tick         = rst ? 4'b0001 : tick_of(state_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_FETCH;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
            retire_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
            if (done) begin
                retire_reg <= retire_reg + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        instr_ack     = 1'b0;
        mul_start     = 1'b0;
        gp_reg_write  = '0;
        sp_reg_write  = '0;
        bus_control   = '0;
        alu_op        = '0;
        done          = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;

        // Reset suppresses every control output so an aborted instruction
        // cannot issue a write at the aborting edge.
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    if (instr_valid) begin
                        sp_reg_write[SP_IR] = 1'b1;
                        instr_ack           = 1'b1;
                        err_next            = 1'b0;
                        state_next          = ST_T2;
                    end
                end

                ST_T2: begin
                    case (opcode)
                        OP_DISP: begin
                            bus_control        = {1'b0, rx};
                            sp_reg_write[SP_H] = 1'b1;
                            done               = 1'b1;
                            state_next         = ST_FETCH;
                        end
                        OP_MOVI: begin
                            bus_control  = BUS_DIN;
                            gp_reg_write = rx_onehot;
                            done         = 1'b1;
                            state_next   = ST_FETCH;
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            bus_control        = {1'b0, rx};
                            sp_reg_write[SP_A] = 1'b1;
                            state_next         = ST_T3;
                        end
                        OP_ADDI: begin
                            bus_control        = BUS_DIN;
                            sp_reg_write[SP_A] = 1'b1;
                            state_next         = ST_T3;
                        end
                        OP_SRL, OP_SLL: begin
                            // Shifts are single-operand: shift rx straight into G.
                            bus_control        = {1'b0, rx};
                            alu_op             = (opcode == OP_SRL) ? ALU_SRL : ALU_SLL;
                            sp_reg_write[SP_G] = 1'b1;
                            state_next         = ST_T3;
                        end
                        default: state_next = ST_FETCH;
                    endcase
                end

                ST_T3: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            bus_control        = {1'b0, ry};
                            alu_op             = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                            sp_reg_write[SP_G] = 1'b1;
                            state_next         = ST_T4;
                        end
                        OP_ADDI: begin
                            // A holds the immediate; add rx to it.
                            bus_control        = {1'b0, rx};
                            alu_op             = ALU_ADD;
                            sp_reg_write[SP_G] = 1'b1;
                            state_next         = ST_T4;
                        end
                        OP_SRL, OP_SLL: begin
                            bus_control  = BUS_G;
                            gp_reg_write = rx_onehot;
                            done         = 1'b1;
                            state_next   = ST_FETCH;
                        end
                        OP_MUL: begin
                            // mul_done is deliberately not looked at here: a
                            // stale completion from an earlier operation must
                            // not be taken as this product.
                            bus_control   = {1'b0, ry};
                            alu_op        = ALU_MUL;
                            mul_start     = 1'b1;
                            wait_cnt_next = '0;
                            state_next    = ST_MUL_WAIT;
                        end
                        default: state_next = ST_FETCH;
                    endcase
                end

                ST_MUL_WAIT: begin
                    // Operands stay on the bus for the whole multiply.
                    bus_control = {1'b0, ry};
                    alu_op      = ALU_MUL;
                    if (mul_done) begin
                        sp_reg_write[SP_G] = 1'b1;
                        state_next         = ST_T4;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        err_next   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end

                ST_T4: begin
                    bus_control  = BUS_G;
                    gp_reg_write = rx_onehot;
                    done         = 1'b1;
                    state_next   = ST_FETCH;
                end

                default: state_next = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// tb_proc_ctrl_seq
// Self-checking bench for proc_ctrl_seq: reset, mid-instruction abort,
// a table of per-instruction latency/write vectors, step-by-step schedules
// for ADD/MOVI/MUL, and randomized instruction streams with noise on
// instr_valid and mul_done. A second instance with a 2-bit counter checks
// retire_count wrap.
module tb_proc_ctrl_seq;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [8:0]  ir;
    logic        mul_done;

    logic        instr_ack, mul_start, done, err;
    logic [7:0]  gp_reg_write;
    logic [3:0]  sp_reg_write, bus_control, tick;
    logic [2:0]  alu_op;
    logic [15:0] retire_count;

    logic        ack_s, ms_s, done_s, err_s;
    logic [7:0]  gp_s;
    logic [3:0]  sp_s, bus_s, tick_s;
    logic [2:0]  alu_s;
    logic [1:0]  retire_s;

    proc_ctrl_seq #(.MUL_TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .ir(ir), .mul_done(mul_done), .mul_start(mul_start),
        .gp_reg_write(gp_reg_write), .sp_reg_write(sp_reg_write),
        .bus_control(bus_control), .alu_op(alu_op), .tick(tick),
        .done(done), .err(err), .retire_count(retire_count)
    );

    proc_ctrl_seq #(.MUL_TIMEOUT(TMO), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ack(ack_s),
        .ir(ir), .mul_done(mul_done), .mul_start(ms_s),
        .gp_reg_write(gp_s), .sp_reg_write(sp_s),
        .bus_control(bus_s), .alu_op(alu_s), .tick(tick_s),
        .done(done_s), .err(err_s), .retire_count(retire_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic model_err = 1'b0;
    int   model_retire = 0;

    // One expected control step plus the inputs to drive during it.
    typedef struct {
        logic       ack;
        logic [3:0] sp;
        logic [7:0] gp;
        logic [3:0] bus;
        logic [2:0] alu;
        logic       ms;
        logic       dn;
        logic [3:0] tk;
        logic       md;   // mul_done to drive (wait steps only)
        logic       wt;   // multiplier wait step
        logic       te;   // timeout expires at the end of this step
    } step_t;

    typedef struct {
        logic [8:0] ir;
        int         done_at;   // MUL: wait cycle raising mul_done, 0 = never
        logic       exp_done;
        int         exp_span;  // ack=1 .. done cycle, or first FETCH cycle after a timeout
        logic [7:0] exp_gp;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic step_t mk(input logic [3:0] tk, input logic [3:0] bus,
                                 input logic [2:0] alu, input logic [3:0] sp,
                                 input logic [7:0] gp, input logic dn);
        step_t s;
        s.ack = 1'b0; s.sp = sp; s.gp = gp; s.bus = bus; s.alu = alu;
        s.ms = 1'b0; s.dn = dn; s.tk = tk; s.md = 1'b0; s.wt = 1'b0; s.te = 1'b0;
        return s;
    endfunction

    task automatic check_step(input string tag, input step_t e);
        check({tag, ".ack"},  {31'd0, instr_ack}, {31'd0, e.ack});
        check({tag, ".sp"},   {28'd0, sp_reg_write}, {28'd0, e.sp});
        check({tag, ".gp"},   {24'd0, gp_reg_write}, {24'd0, e.gp});
        check({tag, ".bus"},  {28'd0, bus_control}, {28'd0, e.bus});
        check({tag, ".alu"},  {29'd0, alu_op}, {29'd0, e.alu});
        check({tag, ".mst"},  {31'd0, mul_start}, {31'd0, e.ms});
        check({tag, ".done"}, {31'd0, done}, {31'd0, e.dn});
        check({tag, ".tick"}, {28'd0, tick}, {28'd0, e.tk});
        check({tag, ".err"},  {31'd0, err}, {31'd0, model_err});
        check({tag, ".ret"},  {16'd0, retire_count}, 32'(model_retire) & 32'hFFFF);
        check({tag, ".ret2"}, {30'd0, retire_s}, 32'(model_retire) & 32'h3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            mul_done    = 1'($urandom);
            ir          = 9'($urandom);
            #2 check_step("idle", mk(4'b0001, 4'd0, 3'd0, 4'd0, 8'd0, 1'b0));
            @(posedge clk);
        end
    endtask

    // Build the step schedule of one instruction from the opcode table and
    // apply it, checking every cycle.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                             input int done_at, input bit noise);
        step_t      q[$];
        step_t      s;
        logic [7:0] w;
        logic [3:0] brx, bry;
        w   = 8'(1) << rx;
        brx = {1'b0, rx};
        bry = {1'b0, ry};
        s = mk(4'b0001, 4'd0, 3'd0, 4'b0001, 8'd0, 1'b0);
        s.ack = 1'b1;
        q.push_back(s);
        case (op)
            3'd0: q.push_back(mk(4'b0010, brx, 3'd0, 4'b1000, 8'd0, 1'b1));
            3'd7: q.push_back(mk(4'b0010, 4'd9, 3'd0, 4'b0000, w, 1'b1));
            3'd1, 3'd3: begin
                q.push_back(mk(4'b0010, brx, 3'd0, 4'b0010, 8'd0, 1'b0));
                q.push_back(mk(4'b0100, bry, (op == 3'd1) ? 3'd0 : 3'd1, 4'b0100, 8'd0, 1'b0));
                q.push_back(mk(4'b1000, 4'd8, 3'd0, 4'b0000, w, 1'b1));
            end
            3'd2: begin
                q.push_back(mk(4'b0010, 4'd9, 3'd0, 4'b0010, 8'd0, 1'b0));
                q.push_back(mk(4'b0100, brx, 3'd0, 4'b0100, 8'd0, 1'b0));
                q.push_back(mk(4'b1000, 4'd8, 3'd0, 4'b0000, w, 1'b1));
            end
            3'd5, 3'd6: begin
                q.push_back(mk(4'b0010, brx, (op == 3'd5) ? 3'd4 : 3'd3, 4'b0100, 8'd0, 1'b0));
                q.push_back(mk(4'b0100, 4'd8, 3'd0, 4'b0000, w, 1'b1));
            end
            default: begin // MUL
                q.push_back(mk(4'b0010, brx, 3'd0, 4'b0010, 8'd0, 1'b0));
                s = mk(4'b0100, bry, 3'd2, 4'b0000, 8'd0, 1'b0);
                s.ms = 1'b1;
                q.push_back(s);
                for (int i = 1; i <= TMO; i++) begin
                    if (done_at != 0 && i > done_at) break;
                    s = mk(4'b0100, bry, 3'd2, (i == done_at) ? 4'b0100 : 4'b0000, 8'd0, 1'b0);
                    s.wt = 1'b1;
                    s.md = (i == done_at);
                    s.te = (done_at == 0 && i == TMO);
                    q.push_back(s);
                end
                if (done_at != 0) q.push_back(mk(4'b1000, 4'd8, 3'd0, 4'b0000, w, 1'b1));
            end
        endcase
        $display("txn op=%0d rx=%0d ry=%0d mul_done_at=%0d steps=%0d", op, rx, ry, done_at, q.size());
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            ir          = {op, rx, ry};
            instr_valid = (k == 0) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            mul_done    = q[k].wt ? q[k].md : (noise ? 1'($urandom) : 1'b0);
            #2 check_step($sformatf("op%0d.s%0d", op, k), q[k]);
            @(posedge clk);
            if (q[k].ack) model_err = 1'b0;
            if (q[k].te)  model_err = 1'b1;
            if (q[k].dn)  model_retire++;
        end
    endtask

    // Table vector: measure span, accumulated GP writes and err, independent
    // of the step schedule above.
    task automatic run_vec(input vec_t v, input int idx);
        int         c;
        int         span;
        logic       saw_done;
        logic [7:0] gp_or;
        c = 1; span = -1; saw_done = 1'b0; gp_or = 8'd0;
        @(negedge clk);
        ir = v.ir; instr_valid = 1'b1; mul_done = 1'b0;
        #2 check($sformatf("vec%0d.ack", idx), {31'd0, instr_ack}, 32'd1);
        @(posedge clk);
        while (c < 40) begin
            c++;
            @(negedge clk);
            instr_valid = 1'b0;
            mul_done    = (v.ir[8:6] == 3'd4 && v.done_at != 0 && c == 3 + v.done_at);
            #2;
            gp_or = gp_or | gp_reg_write;
            if (done) begin
                saw_done = 1'b1; span = c;
                @(posedge clk);
                break;
            end
            if (tick == 4'b0001) begin
                span = c;
                @(posedge clk);
                break;
            end
            @(posedge clk);
        end
        if (saw_done) model_retire++;
        model_err = v.exp_err;
        $display("txn vec%0d ir=%o span=%0d done=%0d", idx, v.ir, span, saw_done);
        @(negedge clk);
        instr_valid = 1'b0; mul_done = 1'b0;
        #2;
        check($sformatf("vec%0d.span", idx), 32'(span), 32'(v.exp_span));
        check($sformatf("vec%0d.done", idx), {31'd0, saw_done}, {31'd0, v.exp_done});
        check($sformatf("vec%0d.gp", idx), {24'd0, gp_or}, {24'd0, v.exp_gp});
        check($sformatf("vec%0d.err", idx), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("vec%0d.ret", idx), {16'd0, retire_count}, 32'(model_retire) & 32'hFFFF);
        @(posedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{9'o730, 0, 1'b1, 2, 8'h08, 1'b0}; // MOVI R3
        vecs[1]  = '{9'o050, 0, 1'b1, 2, 8'h00, 1'b0}; // DISP R5
        vecs[2]  = '{9'o112, 0, 1'b1, 4, 8'h02, 1'b0}; // ADD R1,R2
        vecs[3]  = '{9'o265, 0, 1'b1, 4, 8'h40, 1'b0}; // ADDI R6
        vecs[4]  = '{9'o321, 0, 1'b1, 4, 8'h04, 1'b0}; // SUB R2,R1
        vecs[5]  = '{9'o507, 0, 1'b1, 3, 8'h01, 1'b0}; // SRL R0
        vecs[6]  = '{9'o674, 0, 1'b1, 3, 8'h80, 1'b0}; // SLL R7
        vecs[7]  = '{9'o445, 3, 1'b1, 7, 8'h10, 1'b0}; // MUL R4,R5, done on wait 3
        vecs[8]  = '{9'o401, 1, 1'b1, 5, 8'h01, 1'b0}; // MUL, done on first wait
        vecs[9]  = '{9'o445, 4, 1'b1, 8, 8'h10, 1'b0}; // MUL, done on last allowed wait
        vecs[10] = '{9'o445, 0, 1'b0, 8, 8'h00, 1'b1}; // MUL timeout
        vecs[11] = '{9'o112, 0, 1'b1, 4, 8'h02, 1'b0}; // next ack clears err

        rst = 1'b1; instr_valid = 1'b1; ir = 9'o730; mul_done = 1'b0;

        // Reset held two cycles with instr_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 check_step("reset", mk(4'b0001, 4'd0, 3'd0, 4'd0, 8'd0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0;
        @(posedge clk);
        idle(2);

        // SUB R2,R1 aborted by reset in T3.
        @(negedge clk);
        ir = 9'o321; instr_valid = 1'b1;
        #2 check("abort.ack", {31'd0, instr_ack}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        #2 check("abort.t2bus", {28'd0, bus_control}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2 check_step("abort.t3", mk(4'b0001, 4'd0, 3'd0, 4'd0, 8'd0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        idle(3);
        $display("txn abort SUB in T3");

        // Step-by-step schedules of the directed cases.
        run_instr(3'd7, 3'd3, 3'd0, 0, 1'b0); // MOVI R3
        run_instr(3'd1, 3'd1, 3'd2, 0, 1'b0); // ADD R1,R2
        run_instr(3'd4, 3'd4, 3'd5, 3, 1'b0); // MUL R4,R5
        run_instr(3'd4, 3'd4, 3'd5, 0, 1'b0); // MUL timeout
        idle(1);
        run_instr(3'd0, 3'd6, 3'd1, 0, 1'b0); // clears err

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Randomized stream with noise on ignored inputs.
        for (int n = 0; n < 80; n++) begin
            logic [2:0] op;
            int         da;
            op = 3'($urandom);
            da = (op == 3'd4) ? int'($urandom_range(0, TMO)) : 0;
            run_instr(op, 3'($urandom), 3'($urandom), da, 1'b1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
